// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module   : pipe_ctrl_pkg
// Purpose  : Shared FSM state type and pipeline-register indices for the
//            5-stage core's hazard control.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    localparam int NREG       = 4;
    localparam int STG_IF_ID  = 0;
    localparam int STG_ID_EX  = 1;
    localparam int STG_EX_MEM = 2;
    localparam int STG_MEM_WB = 3;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LU_KILL = 2'd1,
        RD_KILL = 2'd2
    } hz_state_t;

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Purpose  : Up-counter that sticks at all-ones instead of wrapping.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : PC enable and per-stage en/flush generation for load-use stalls,
//            EX redirects and data-memory wait. Optional perf counters are
//            built when PIPE_HAZARD_CTRL_PERF_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int RA_W = 5,
    parameter int NREG = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_wait,
    input  logic            ex_redirect,
    input  logic            ex_is_load,
    input  logic [RA_W-1:0] ex_rd,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic            id_uses_rs1,
    input  logic            id_uses_rs2,
    output logic            pc_en,
    output logic [NREG-1:0] stg_en,
    output logic [NREG-1:0] stg_flush
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_redirect_cnt
`endif
);

    hz_state_t state;
    hz_state_t state_nxt;
    logic      lu;

    assign lu = ex_is_load && (ex_rd != '0) &&
                ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                 (id_uses_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        pc_en     = 1'b1;
        stg_en    = '1;
        stg_flush = '0;
        state_nxt = state;
        if (rst) begin
            pc_en     = 1'b0;
            stg_en    = '0;
            state_nxt = RUN;
        end else if (mem_wait) begin
            // Freeze holds everything, including the FSM position.
            pc_en  = 1'b0;
            stg_en = '0;
        end else begin
            case (state)
                RUN: begin
                    if (ex_redirect) begin
                        state_nxt = RD_KILL;
                    end else if (lu) begin
                        pc_en             = 1'b0;
                        stg_en[STG_IF_ID] = 1'b0;
                        state_nxt         = LU_KILL;
                    end
                end
                LU_KILL: begin
                    // Bubble into ID/EX kills the duplicate captured last cycle.
                    pc_en                = 1'b0;
                    stg_en[STG_IF_ID]    = 1'b0;
                    stg_flush[STG_ID_EX] = 1'b1;
                    state_nxt            = RUN;
                end
                RD_KILL: begin
                    pc_en                = 1'b0;
                    stg_flush[STG_IF_ID] = 1'b1;
                    stg_flush[STG_ID_EX] = 1'b1;
                    state_nxt            = RUN;
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic redirect_evt;
    logic stall_evt;

    assign redirect_evt = (state == RUN) && (state_nxt == RD_KILL) && !rst;
    assign stall_evt    = !pc_en && !rst;

    sat_counter #(.WIDTH(32)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_evt),
        .count (perf_stall_cnt)
    );

    sat_counter #(.WIDTH(32)) u_redirect_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (redirect_evt),
        .count (perf_redirect_cnt)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Directed and randomized checks of pipe_hazard_ctrl against a
//            behavioural model (perf checks when PIPE_HAZARD_CTRL_PERF_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

    localparam int RA_W = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            mem_wait;
    logic            ex_redirect;
    logic            ex_is_load;
    logic [RA_W-1:0] ex_rd;
    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic            id_uses_rs1;
    logic            id_uses_rs2;
    logic            pc_en;
    logic [3:0]      stg_en;
    logic [3:0]      stg_flush;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0]     perf_stall_cnt;
    logic [31:0]     perf_redirect_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Model: how many kill cycles are owed and of which kind.
    // 0 = nothing pending, 1 = load-use bubble owed, 2 = redirect kill owed.
    int          owed = 0;
    longint      m_stalls = 0;
    longint      m_redirects = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.RA_W(RA_W), .NREG(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_wait    (mem_wait),
        .ex_redirect (ex_redirect),
        .ex_is_load  (ex_is_load),
        .ex_rd       (ex_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .pc_en       (pc_en),
        .stg_en      (stg_en),
        .stg_flush   (stg_flush)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        ,
        .perf_stall_cnt    (perf_stall_cnt),
        .perf_redirect_cnt (perf_redirect_cnt)
`endif
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_in(input logic r, input logic mw, input logic rd_o,
                          input logic ld, input int erd, input int rs1,
                          input int rs2, input logic u1, input logic u2);
        rst = r; mem_wait = mw; ex_redirect = rd_o; ex_is_load = ld;
        ex_rd = RA_W'(erd); id_rs1 = RA_W'(rs1); id_rs2 = RA_W'(rs2);
        id_uses_rs1 = u1; id_uses_rs2 = u2;
    endtask

    // Check current outputs (mid-cycle), then step model and DUT one cycle.
    task automatic step(input string tag);
        logic       e_pc;
        logic [3:0] e_en;
        logic [3:0] e_fl;
        int         nxt;
        bit         hazard;
        #1;
        hazard = ex_is_load && (int'(ex_rd) != 0) &&
                 ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        nxt = owed;
        if (rst) begin
            e_pc = 0; e_en = 4'b0000; e_fl = 4'b0000; nxt = 0;
        end else if (mem_wait) begin
            e_pc = 0; e_en = 4'b0000; e_fl = 4'b0000;
        end else if (owed == 1) begin
            e_pc = 0; e_en = 4'b1110; e_fl = 4'b0010; nxt = 0;
        end else if (owed == 2) begin
            e_pc = 0; e_en = 4'b1111; e_fl = 4'b0011; nxt = 0;
        end else if (ex_redirect) begin
            e_pc = 1; e_en = 4'b1111; e_fl = 4'b0000; nxt = 2;
        end else if (hazard) begin
            e_pc = 0; e_en = 4'b1110; e_fl = 4'b0000; nxt = 1;
        end else begin
            e_pc = 1; e_en = 4'b1111; e_fl = 4'b0000;
        end

        checks++;
        assert (pc_en === e_pc) else begin
            errors++;
            $error("FAIL %s pc_en: got %b expected %b", tag, pc_en, e_pc);
        end
        checks++;
        assert (stg_en === e_en) else begin
            errors++;
            $error("FAIL %s stg_en: got %b expected %b", tag, stg_en, e_en);
        end
        checks++;
        assert (stg_flush === e_fl) else begin
            errors++;
            $error("FAIL %s stg_flush: got %b expected %b", tag, stg_flush, e_fl);
        end
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        checks++;
        assert (perf_stall_cnt === 32'(m_stalls)) else begin
            errors++;
            $error("FAIL %s perf_stall_cnt: got %0d expected %0d", tag, perf_stall_cnt, m_stalls);
        end
        checks++;
        assert (perf_redirect_cnt === 32'(m_redirects)) else begin
            errors++;
            $error("FAIL %s perf_redirect_cnt: got %0d expected %0d", tag, perf_redirect_cnt, m_redirects);
        end
`endif
        if (rst) begin
            m_stalls = 0; m_redirects = 0;
        end else begin
            if (!e_pc) m_stalls++;
            if (owed == 0 && nxt == 2) m_redirects++;
        end
        owed = nxt;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        step("reset0");
        step("reset1");

        // Load-use on rs1: stall, bubble, then normal.
        set_in(0, 0, 0, 1, 5, 5, 9, 1, 0);
        step("lu_t");
        set_in(0, 0, 0, 0, 7, 5, 9, 1, 0);
        step("lu_t1");
        step("lu_t2");

        // Load to x0 never stalls.
        set_in(0, 0, 0, 1, 0, 3, 0, 0, 1);
        step("x0_load");

        // Redirect alone, then redirect colliding with load-use.
        set_in(0, 0, 1, 0, 0, 0, 0, 0, 0);
        step("rd_t");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rd_t1");
        step("rd_t2");
        set_in(0, 0, 1, 1, 4, 1, 4, 0, 1);
        step("rdlu_t");
        step("rdlu_t1");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rdlu_t2");

        // mem_wait for 3 cycles during LU_KILL.
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rst_perf");
        set_in(0, 0, 0, 1, 6, 2, 6, 0, 1);
        step("mw_lu");
        set_in(0, 1, 1, 1, 6, 2, 6, 0, 1);
        step("mw_f0");
        step("mw_f1");
        step("mw_f2");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("mw_kill");
        step("mw_run");

        // Back-to-back load-use right after LU_KILL.
        set_in(0, 0, 0, 1, 8, 8, 0, 1, 0);
        step("b2b_a");
        step("b2b_kill");
        step("b2b_again");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("b2b_kill2");

        // Reset lands while in RD_KILL.
        set_in(0, 0, 1, 0, 0, 0, 0, 0, 0);
        step("rstk_rd");
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rstk_rst");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rstk_run");

        // Randomized traffic with small register range to provoke hits.
        for (int i = 0; i < 600; i++) begin
            set_in(($urandom_range(0, 59) == 0), ($urandom_range(0, 4) == 0),
                   ($urandom_range(0, 5) == 0), ($urandom_range(0, 1) == 1),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1),
                   ($urandom_range(0, 1) == 1));
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
